// File: rtl/dbus_responder_if.sv
// Data-bus port between the core MEM stage and the dbus responder.
// Single-cycle access, no wait states.
interface dbus_responder_if;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [3:0]  sel_i;
   logic [31:0] data_i;
   logic [31:0] data_o;

   modport master (
      output ce_i,
      output we_i,
      output addr_i,
      output sel_i,
      output data_i,
      input  data_o
   );

   modport slave (
      input  ce_i,
      input  we_i,
      input  addr_i,
      input  sel_i,
      input  data_i,
      output data_o
   );
endinterface

// File: rtl/dbus_responder.sv
// Data-bus responder: on-chip byte-lane RAM plus timer/compare and GPIO
// registers; the timer pending flag drives the core interrupt vector.
module dbus_responder #(
   parameter int RAM_AW = 10,
   parameter int GPIO_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   dbus_responder_if.slave   bus,
   output logic [5:0]        int_o,
   output logic [GPIO_W-1:0] gpio_o,
   input  logic [GPIO_W-1:0] gpio_i
);

   localparam int DEPTH = 1 << RAM_AW;

   localparam logic [5:0] OFF_CNT  = 6'd0;
   localparam logic [5:0] OFF_CMP  = 6'd1;
   localparam logic [5:0] OFF_CTRL = 6'd2;
   localparam logic [5:0] OFF_STAT = 6'd3;
   localparam logic [5:0] OFF_GOUT = 6'd4;
   localparam logic [5:0] OFF_GIN  = 6'd5;

   logic [31:0]       mem [DEPTH];

   logic [31:0]       cnt_q;
   logic [31:0]       cnt_d;
   logic [31:0]       cnt_run;
   logic [31:0]       cmp_q;
   logic [31:0]       cmp_d;
   logic [2:0]        ctrl_q;
   logic [2:0]        ctrl_d;
   logic              pend_q;
   logic              pend_d;
   logic              int_q;
   logic [GPIO_W-1:0] gpio_q;
   logic [GPIO_W-1:0] gpio_d;
   logic [GPIO_W-1:0] sync1_q;
   logic [GPIO_W-1:0] sync2_q;

   logic              ram_hit;
   logic              reg_hit;
   logic              wr;
   logic              rd;
   logic              ram_we;
   logic              wr_reg;
   logic [5:0]        off;
   logic [RAM_AW-1:0] widx;
   logic              match;
   logic              pend_set;
   logic              w1c;
   logic [31:0]       rd_ram;
   logic [31:0]       rd_reg;
   logic              unused_addr;

   function automatic logic [31:0] lane_merge(
      input logic [31:0] old,
      input logic [31:0] nw,
      input logic [3:0]  sel
   );
      logic [31:0] r;
      for (int k = 0; k < 4; k++) begin
         r[8*k +: 8] = sel[k] ? nw[8*k +: 8] : old[8*k +: 8];
      end
      return r;
   endfunction

   // Bits [1:0] and the RAM alias bits carry no information here.
   assign unused_addr = ^{bus.addr_i[1:0], bus.addr_i[15:RAM_AW+2]};

   assign ram_hit = (bus.addr_i[31:16] == 16'h0000);
   assign reg_hit = (bus.addr_i[31:8] == 24'h100000);
   assign off     = bus.addr_i[7:2];
   assign widx    = bus.addr_i[RAM_AW+1:2];

   assign wr      = bus.ce_i & bus.we_i & rst;
   assign rd      = bus.ce_i & ~bus.we_i & rst;
   assign ram_we  = wr & ram_hit & (|bus.sel_i);
   assign wr_reg  = wr & reg_hit & (|bus.sel_i);

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.sel_i[k]) begin
               mem[widx][8*k +: 8] <= bus.data_i[8*k +: 8];
            end
         end
      end
   end

   assign rd_ram = mem[widx];

   always_comb begin
      match    = (cnt_q == cmp_q);
      pend_set = ctrl_q[0] & match;
      cnt_run  = cnt_q;
      if (ctrl_q[0]) begin
         cnt_run = (match && ctrl_q[1]) ? 32'd0 : cnt_q + 32'd1;
      end
   end

   // CPU writes override the running count lane by lane.
   always_comb begin
      cnt_d  = cnt_run;
      cmp_d  = cmp_q;
      ctrl_d = ctrl_q;
      gpio_d = gpio_q;
      w1c    = 1'b0;
      if (wr_reg) begin
         unique case (off)
            OFF_CNT:  cnt_d = lane_merge(cnt_run, bus.data_i, bus.sel_i);
            OFF_CMP:  cmp_d = lane_merge(cmp_q, bus.data_i, bus.sel_i);
            OFF_CTRL: ctrl_d = bus.sel_i[0] ? bus.data_i[2:0] : ctrl_q;
            OFF_STAT: w1c = bus.sel_i[0] & bus.data_i[0];
            OFF_GOUT: begin
               for (int i = 0; i < GPIO_W; i++) begin
                  gpio_d[i] = bus.sel_i[i/8] ? bus.data_i[i] : gpio_q[i];
               end
            end
            default: ;
         endcase
      end
      pend_d = pend_set | (pend_q & ~w1c);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= 32'd0;
         cmp_q   <= 32'hFFFF_FFFF;
         ctrl_q  <= 3'd0;
         pend_q  <= 1'b0;
         int_q   <= 1'b0;
         gpio_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
         ctrl_q  <= ctrl_d;
         pend_q  <= pend_d;
         int_q   <= pend_d & ctrl_d[2];
         gpio_q  <= gpio_d;
         sync1_q <= gpio_i;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      rd_reg = '0;
      unique case (off)
         OFF_CNT:  rd_reg = cnt_q;
         OFF_CMP:  rd_reg = cmp_q;
         OFF_CTRL: rd_reg[2:0] = ctrl_q;
         OFF_STAT: rd_reg[0] = pend_q;
         OFF_GOUT: rd_reg[GPIO_W-1:0] = gpio_q;
         OFF_GIN:  rd_reg[GPIO_W-1:0] = sync2_q;
         default:  rd_reg = '0;
      endcase
   end

   always_comb begin
      bus.data_o = '0;
      if (rd) begin
         unique case (1'b1)
            ram_hit: bus.data_o = rd_ram;
            reg_hit: bus.data_o = rd_reg;
            default: bus.data_o = '0;
         endcase
      end
   end

   assign int_o  = {5'd0, int_q};
   assign gpio_o = gpio_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: vector table for RAM/decode,
// hand sequences for timer, collisions, GPIO sync and reset.
module tb_dbus_responder;

   localparam logic [31:0] R_CNT  = 32'h1000_0000;
   localparam logic [31:0] R_CMP  = 32'h1000_0004;
   localparam logic [31:0] R_CTRL = 32'h1000_0008;
   localparam logic [31:0] R_STAT = 32'h1000_000C;
   localparam logic [31:0] R_GOUT = 32'h1000_0010;
   localparam logic [31:0] R_GIN  = 32'h1000_0014;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] int_o;
   logic [7:0] gpio_o;
   logic [7:0] gpio_i;

   int errs   = 0;
   int checks = 0;

   dbus_responder_if bus();

   dbus_responder #(
      .RAM_AW (10),
      .GPIO_W (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .int_o  (int_o),
      .gpio_o (gpio_o),
      .gpio_i (gpio_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      bus.ce_i   = 1'b1;
      bus.we_i   = 1'b1;
      bus.addr_i = a;
      bus.data_i = d;
      bus.sel_i  = s;
      @(posedge clk);
      #1;
      bus.ce_i = 1'b0;
      bus.we_i = 1'b0;
      bus.sel_i = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.ce_i   = 1'b1;
      bus.we_i   = 1'b0;
      bus.addr_i = a;
      bus.sel_i  = 4'hF;
      #1;
      d = bus.data_o;
      bus.ce_i  = 1'b0;
      bus.sel_i = 4'h0;
   endtask

   task automatic rchk(input string name, input logic [31:0] a,
                       input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(name, d, exp);
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] seq [6];

      bus.ce_i   = 1'b0;
      bus.we_i   = 1'b0;
      bus.addr_i = '0;
      bus.sel_i  = '0;
      bus.data_i = '0;
      gpio_i     = 8'h00;
      rst        = 1'b0;

      tbl[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0};
      tbl[1]  = '{1'b1, 32'h0000_0010, 4'h4, 32'hAABB_CCDD, 32'h0};
      tbl[2]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h11BB_3344};
      tbl[3]  = '{1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0};
      tbl[4]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h11BB_3344};
      tbl[5]  = '{1'b1, 32'h0000_0014, 4'hF, 32'hDEAD_BEEF, 32'h0};
      tbl[6]  = '{1'b0, 32'h0000_1014, 4'hF, 32'h0, 32'hDEAD_BEEF};
      tbl[7]  = '{1'b1, 32'h0001_0010, 4'hF, 32'h5555_5555, 32'h0};
      tbl[8]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h11BB_3344};
      tbl[9]  = '{1'b0, 32'h2000_0000, 4'hF, 32'h0, 32'h0};
      tbl[10] = '{1'b1, R_GOUT,        4'hF, 32'h0000_01A5, 32'h0};
      tbl[11] = '{1'b0, R_GOUT,        4'hF, 32'h0, 32'h0000_00A5};
      tbl[12] = '{1'b1, 32'h1000_0020, 4'hF, 32'h1234_5678, 32'h0};
      tbl[13] = '{1'b0, 32'h1000_0020, 4'hF, 32'h0, 32'h0};
      tbl[14] = '{1'b1, R_CTRL,        4'hE, 32'h0000_00FF, 32'h0};
      tbl[15] = '{1'b0, R_CTRL,        4'hF, 32'h0, 32'h0};

      // reset state
      idle(2);
      chk("rst_int_o", {26'd0, int_o}, 32'h0);
      chk("rst_gpio_o", {24'd0, gpio_o}, 32'h0);
      rchk("rst_data_o", R_CMP, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      idle(1);
      rchk("rst_cnt", R_CNT, 32'h0);
      rchk("rst_cmp", R_CMP, 32'hFFFF_FFFF);
      rchk("rst_ctrl", R_CTRL, 32'h0);
      rchk("rst_stat", R_STAT, 32'h0);

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].we) begin
            wr(tbl[i].addr, tbl[i].data, tbl[i].sel);
         end else begin
            rd(tbl[i].addr, d);
            chk($sformatf("vec%0d", i), d, tbl[i].exp);
         end
      end
      chk("gpio_o_trunc", {24'd0, gpio_o}, 32'h0000_00A5);

      // idle bus and write cycles both read zero
      bus.ce_i   = 1'b0;
      bus.addr_i = 32'h0000_0010;
      #1;
      chk("ce0_data", bus.data_o, 32'h0);
      bus.ce_i   = 1'b1;
      bus.we_i   = 1'b1;
      bus.sel_i  = 4'h0;
      #1;
      chk("we1_data", bus.data_o, 32'h0);
      bus.ce_i = 1'b0;
      bus.we_i = 1'b0;

      // GPIO synchronizer
      gpio_i = 8'h3C;
      idle(1);
      rchk("gin_1edge", R_GIN, 32'h0);
      idle(1);
      rchk("gin_2edge", R_GIN, 32'h3C);
      wr(R_GIN, 32'hFFFF_FFFF, 4'hF);
      rchk("gin_ro", R_GIN, 32'h3C);

      // timer one-shot
      wr(R_CMP, 32'd5, 4'hF);
      wr(R_CNT, 32'd0, 4'hF);
      wr(R_CTRL, 32'h5, 4'hF);
      for (int i = 1; i <= 5; i++) begin
         idle(1);
         rchk($sformatf("os_cnt%0d", i), R_CNT, i);
         chk($sformatf("os_int%0d", i), {31'd0, int_o[0]}, 32'h0);
      end
      idle(1);
      chk("os_int_rise", {26'd0, int_o}, 32'h1);
      rchk("os_pend", R_STAT, 32'h1);
      rchk("os_cnt6", R_CNT, 32'd6);
      idle(1);
      rchk("os_cnt7", R_CNT, 32'd7);
      wr(R_STAT, 32'h1, 4'hF);
      chk("os_w1c_int", {26'd0, int_o}, 32'h0);
      rchk("os_w1c_pend", R_STAT, 32'h0);
      wr(R_CTRL, 32'h0, 4'hF);

      // auto-reload
      wr(R_CMP, 32'd2, 4'hF);
      wr(R_CNT, 32'd0, 4'hF);
      wr(R_CTRL, 32'h3, 4'hF);
      seq = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
      for (int i = 0; i < 6; i++) begin
         rchk($sformatf("ar_seq%0d", i), R_CNT, seq[i]);
         idle(1);
      end
      chk("ar_no_ie", {26'd0, int_o}, 32'h0);
      rchk("ar_pend", R_STAT, 32'h1);
      wr(R_CTRL, 32'h0, 4'hF);
      wr(R_STAT, 32'h1, 4'h1);
      rchk("ar_clr", R_STAT, 32'h0);

      // wrap
      wr(R_CNT, 32'hFFFF_FFFE, 4'hF);
      wr(R_CMP, 32'd5, 4'hF);
      wr(R_CTRL, 32'h1, 4'hF);
      rchk("wr_fe", R_CNT, 32'hFFFF_FFFE);
      idle(1);
      rchk("wr_ff", R_CNT, 32'hFFFF_FFFF);
      idle(1);
      rchk("wr_0", R_CNT, 32'h0);
      idle(1);
      rchk("wr_1", R_CNT, 32'h1);

      // CNT write vs increment, full and partial lanes
      wr(R_CNT, 32'h100, 4'hF);
      rchk("col_cnt", R_CNT, 32'h100);
      idle(1);
      rchk("col_inc", R_CNT, 32'h101);
      wr(R_CNT, 32'h0000_00AA, 4'h1);
      rchk("col_lane", R_CNT, 32'h1AA);

      // W1C on the match edge: set wins
      wr(R_CMP, 32'h20, 4'hF);
      wr(R_CTRL, 32'h5, 4'hF);
      wr(R_CNT, 32'h1E, 4'hF);
      idle(2);
      rchk("col_pre", R_CNT, 32'h20);
      rchk("col_pre_pend", R_STAT, 32'h0);
      wr(R_STAT, 32'h1, 4'hF);
      rchk("col_set_wins", R_STAT, 32'h1);
      chk("col_int", {26'd0, int_o}, 32'h1);

      // asynchronous reset mid-count
      #2;
      rst = 1'b0;
      #1;
      chk("arst_int", {26'd0, int_o}, 32'h0);
      chk("arst_gpio", {24'd0, gpio_o}, 32'h0);
      rchk("arst_data", R_CNT, 32'h0);
      idle(1);
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      rchk("arst_cnt", R_CNT, 32'h0);
      rchk("arst_ctrl", R_CTRL, 32'h0);
      rchk("arst_gin", R_GIN, 32'h3C);
      rchk("arst_ram", 32'h0000_0010, 32'h11BB_3344);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
